cpu_run_monitor: RTL and testbench

//  Cycle-budget run controller for the MIPS core. Sequences the CPU reset, counts
//  run cycles and detects program end. End is either a HALT instruction word or a
//  PC self-loop held for STALL_LIMIT cycles. It flags timeout when the budget expires.
//  It sits beside the MIPS instance in benches and FPGA wrappers, and replaces the

---
 rtl/cpu_run_monitor.sv | 116 +++++++++++
 tb/tb_cpu_run_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Cycle-budget run controller for a MIPS core: sequences CPU reset, counts RUN
// cycles and ends the run on a HALT word, a stalled PC, or budget exhaustion.
module cpu_run_monitor #(
   parameter int          MAX_CYCLES  = 100,
   parameter int          CNT_W       = 16,
   parameter int          ADDR_W      = 32,
   parameter int          RST_CYCLES  = 2,
   parameter int          STALL_LIMIT = 4,
   parameter logic [31:0] HALT_WORD   = 32'hFC000000,
   parameter logic [1:0]  MODE        = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [31:0]       instr_in,
   output logic              cpu_rst,
   output logic              running,
   output logic              done,
   output logic              halted,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int RC_W = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
   localparam int SC_W = $clog2(STALL_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [RC_W-1:0]   rcnt_q, rcnt_d;
   logic [SC_W-1:0]   stall_q, stall_d;
   logic [ADDR_W-1:0] last_pc_q, last_pc_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;

   logic pc_match, halt_hit, budget_hit;

   // The first RUN cycle (count still 0) never compares against last PC.
   assign pc_match   = (cycle_q != '0) && (pc_in == last_pc_q);
   assign halt_hit   = (MODE[0] && (instr_in == HALT_WORD)) ||
                       (MODE[1] && pc_match && (stall_q == SC_W'(STALL_LIMIT - 2)));
   assign budget_hit = (cycle_q == CNT_W'(MAX_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RST;
         S_RST:   if (!start && rcnt_q == '0) state_d = S_RUN;
         S_RUN:   if (start) state_d = S_RST;
                  else if (halt_hit || budget_hit) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RST;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_rst     = (state_q != S_RUN);
      running     = (state_q == S_RUN);
      done        = (state_q == S_DONE);
      halted      = halted_q;
      timeout     = timeout_q;
      cycle_count = cycle_q;
   end

   always_comb begin
      rcnt_d    = rcnt_q;
      stall_d   = stall_q;
      last_pc_d = last_pc_q;
      cycle_d   = cycle_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      if (start) begin
         rcnt_d    = RC_W'(RST_CYCLES - 1);
         stall_d   = '0;
         cycle_d   = '0;
         halted_d  = 1'b0;
         timeout_d = 1'b0;
      end else if (state_q == S_RST) begin
         if (rcnt_q != '0) rcnt_d = rcnt_q - RC_W'(1);
      end else if (state_q == S_RUN) begin
         cycle_d   = cycle_q + CNT_W'(1);
         last_pc_d = pc_in;
         // Saturate so a disabled PC-loop detector cannot wrap the counter.
         if (!pc_match)                               stall_d = '0;
         else if (stall_q != SC_W'(STALL_LIMIT - 1)) stall_d = stall_q + SC_W'(1);
         if (halt_hit)        halted_d  = 1'b1;
         else if (budget_hit) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt_q    <= '0;
         stall_q   <= '0;
         last_pc_q <= '0;
         cycle_q   <= '0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         rcnt_q    <= rcnt_d;
         stall_q   <= stall_d;
         last_pc_q <= last_pc_d;
         cycle_q   <= cycle_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor; expected run endings come from a
// per-run model over the planned PC/instruction sequence.
module tb_cpu_run_monitor;

   localparam int          MAXC = 100;
   localparam int          SL   = 4;
   localparam logic [31:0] HALT = 32'hFC000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] pc_in = '0;
   logic [31:0] instr_in = '0;
   logic        cpu_rst, running, done, halted, timeout;
   logic [15:0] cycle_count;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] pcs [0:MAXC];
   logic [31:0] ins [0:MAXC];

   cpu_run_monitor #(
      .MAX_CYCLES(MAXC), .CNT_W(16), .ADDR_W(32), .RST_CYCLES(2),
      .STALL_LIMIT(SL), .HALT_WORD(HALT), .MODE(2'b11)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .instr_in(instr_in),
      .cpu_rst(cpu_rst), .running(running), .done(done), .halted(halted),
      .timeout(timeout), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = w ^ 32'h1;
      return w;
   endfunction

   // kind 0: random PCs with frequent repeats, maybe a HALT word
   // kind 1: incrementing PC, no halt; kind 2: HALT at cycle p
   // kind 3: incrementing PC then held at 0x40 from cycle p
   task automatic gen(input int kind, input int p);
      for (int k = 0; k <= MAXC; k++) begin
         pcs[k] = 32'h1000 + 32'(k) * 4;
         ins[k] = rnd_instr();
      end
      if (kind == 0) begin
         pcs[1] = pc_in;
         for (int k = 2; k <= MAXC; k++)
            pcs[k] = ($urandom_range(0, 3) == 0) ? pcs[k-1] : 32'h2000 + ($urandom & 32'hFC);
         if ($urandom_range(0, 1) == 1) ins[$urandom_range(1, MAXC)] = HALT;
      end else if (kind == 2) begin
         ins[p] = HALT;
      end else if (kind == 3) begin
         for (int k = p; k <= MAXC; k++) pcs[k] = 32'h40;
      end
   endtask

   // Reference: a run ends at the first cycle carrying HALT or closing a
   // window of SL equal PCs that lies wholly inside the run; else at MAXC.
   task automatic model(output int end_k, output logic hlt);
      bit eq;
      end_k = MAXC;
      hlt   = 1'b0;
      for (int k = 1; k <= MAXC; k++) begin
         eq = (k >= SL);
         for (int j = k - SL + 1; eq && j < k; j++)
            if (pcs[j] != pcs[k]) eq = 0;
         if (ins[k] == HALT || eq) begin
            end_k = k;
            hlt   = 1'b1;
            break;
         end
      end
   endtask

   task automatic start_seq();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rst1_cpu_rst", cpu_rst, 1);
      chk("rst1_running", running, 0);
      chk("rst1_count", cycle_count, 0);
      chk("rst1_status", {done, halted, timeout}, 0);
      @(posedge clk); #1;
      chk("rst2_cpu_rst", cpu_rst, 1);
      chk("rst2_running", running, 0);
      @(posedge clk); #1;
      chk("run_cpu_rst", cpu_rst, 0);
      chk("run_running", running, 1);
      chk("run_count0", cycle_count, 0);
   endtask

   task automatic body(input int kind, input int p, input int abort_at);
      int   end_k;
      logic hlt;
      logic [15:0] cnt_f;
      gen(kind, p);
      model(end_k, hlt);
      for (int k = 1; k <= MAXC; k++) begin
         chk("run_running", running, 1);
         chk("run_count", cycle_count, 32'(k - 1));
         pc_in    = pcs[k];
         instr_in = ins[k];
         if (k == abort_at) begin
            start_seq();
            return;
         end
         @(posedge clk); #1;
         if (k == end_k) break;
      end
      chk("end_done", done, 1);
      chk("end_running", running, 0);
      chk("end_cpu_rst", cpu_rst, 1);
      chk("end_halted", halted, hlt);
      chk("end_timeout", timeout, !hlt);
      chk("end_count", cycle_count, 32'(end_k));
      cnt_f = 16'(end_k);
      for (int i = 0; i < 3; i++) begin
         pc_in    = pcs[1];
         instr_in = (i == 0) ? HALT : rnd_instr();
         @(posedge clk); #1;
      end
      chk("frz_done", done, 1);
      chk("frz_count", cycle_count, cnt_f);
      chk("frz_status", {halted, timeout}, {hlt, !hlt});
   endtask

   initial begin
      #1;
      chk("por_outputs", {cpu_rst, running, done, halted, timeout}, 5'b10000);
      chk("por_count", cycle_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_cpu_rst", cpu_rst, 1);

      // HALT word at RUN cycle 10
      start_seq(); body(2, 10, 0);
      // budget exhausted
      start_seq(); body(1, 0, 0);
      // PC held at 0x40 from cycle 5
      start_seq(); body(3, 5, 0);
      // HALT and budget coincide
      start_seq(); body(2, MAXC, 0);
      // abort at cycle 30, then a fresh run
      start_seq(); body(1, 0, 30); body(0, 0, 0);

      // asynchronous reset mid-run
      start_seq();
      for (int k = 0; k < 7; k++) begin
         pc_in = 32'h3000 + 32'(k) * 4;
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_outputs", {cpu_rst, running, done, halted, timeout}, 5'b10000);
      chk("arst_count", cycle_count, 0);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("arst_idle", {cpu_rst, running, done}, 3'b100);

      for (int r = 0; r < 25; r++) begin
         int kind;
         kind = $urandom_range(0, 3);
         start_seq();
         body(kind, (kind == 2) ? $urandom_range(1, MAXC) : $urandom_range(2, 90), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
